a2d_intf: RTL and testbench
===========================

# a2d_intf

Responder side of the motion controller's conversion handshake. Accepts `strt_cnv` and a 3-bit channel number, then runs two back-to-back 16-bit SPI transactions with the external 8-channel 12-bit ADC. The first transaction selects the channel; the second returns the sample. It then presents the 12-bit result on `res` and raises `cnv_cmplt`. It sits between the motion controller and the board's ADC pins.

## Interface
Parameters:
- `SCLK_DIV_W`, default 5: SCLK divider width. SCLK period is 2^SCLK_DIV_W clk (32).
- `GAP_CLKS`, default 2: number of clk that SS_n is high between the two transactions.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `strt_cnv`  in  1  one-clk pulse that starts a conversion.
- `chnnl`  in  3  ADC channel; sampled when `strt_cnv` is accepted.
- `cnv_cmplt`  out  1  result valid. Level signal; held until the next accepted `strt_cnv`.
- `res`  out  12  conversion result; holds its value until the next completion.
- `SS_n`  out  1  ADC chip select, active low.
- `SCLK`  out  1  SPI clock; idles high.
- `MOSI`  out  1  serial data to the ADC, MSB first.
- `MISO`  in  1  serial data from the ADC.

## Operation
Reset values:
- `SS_n`=1, `SCLK`=1, `MOSI`=0, `cnv_cmplt`=0, `res`=0, state IDLE.

Accepting a request:
- `strt_cnv` is accepted only in IDLE. It is ignored in every other state; a busy conversion is never restarted.
- On acceptance: latch `chnnl`, clear `cnv_cmplt`, load the TX frame {2'b00, chnnl, 11'h000}, go to XFER1.

States:
- IDLE -> XFER1 on `strt_cnv`.
- XFER1 -> GAP when transaction 1 finishes (RX data discarded).
- GAP -> XFER2 after `GAP_CLKS` clk.
- XFER2 -> DONE when transaction 2 finishes. The same TX frame is resent; its content is don't-care for the ADC.
- DONE -> IDLE after one clk. In DONE: `res` <= rx[11:0]; `cnv_cmplt` <= 1.

SPI transaction, one 16-bit frame:
- SS_n falls and the divider is loaded with 5'b10111. The divider increments every clk, and `SCLK` = divider MSB.
- MOSI = shift-register MSB. It is valid 9 clk before the first SCLK fall, which satisfies setup before the first rise.
- SCLK rise (divider 15->16): sample MISO into a holding flop.
- SCLK fall (divider 31->0): shift the register left, inserting the held MISO bit.
- After the 16th rise, SCLK stays high. At divider 31, the final shift happens and SS_n rises in the same clk; no 17th fall is generated.
- RX data = ADC bits, MSB first; the 12 LSBs are the sample.

Arithmetic:
- `res` is unsigned 12-bit, taken directly from the frame; no scaling.

Reset mid-operation:
- Asynchronous return to the reset values.
- No partial `res` update. Any partial SPI frame is abandoned with SS_n high.

## Timing
- SS_n is low for exactly 520 clk per transaction: 9-clk front porch, 15×32, 16-clk last half-period, 15-clk back porch.
- Latency, from the clk edge that accepts `strt_cnv` to `cnv_cmplt` high: 520 + GAP_CLKS + 520 + 1 = 1043 clk with the defaults.
- `res` and `cnv_cmplt` update on the same edge.
- `cnv_cmplt` falls on the edge that accepts the next `strt_cnv`.
- `strt_cnv` arriving on the same clk that DONE returns to IDLE is not accepted; it must come once IDLE is reached.

## Configuration
- `A2D_INV_RES_EN` defined: `res` = ~rx[11:0]. This compensates for the IR sensor front end, where more reflection gives a lower ADC code.
- `A2D_INV_RES_EN` undefined: `res` = rx[11:0] unchanged.
- Latency and SPI timing are identical in both builds.

## Structure
- Package `a2d_pkg` holds:
  - the state enum `a2d_state_t` (IDLE, XFER1, GAP, XFER2, DONE);
  - `A2D_FRAME_PAD` (2'b00);
  - `SCLK_LOAD` (5'b10111);
  - `FRAME_BITS` (16).
- Sub-module `spi_mstr16` is natural: 16-bit master with `wrt`, `cmd[15:0]`, `done`, `rd_data[15:0]`, and the SPI pins. a2d_intf sequences it twice.

## Test plan
- ADC model returns 12'hA5C for channel 4. Pulse `strt_cnv` with `chnnl`=4 -> MOSI frame 1 = 16'h2000; `cnv_cmplt` high 1043 clk later; `res`=12'hA5C (12'h5A3 with `A2D_INV_RES_EN`).
- Measure SPI timing on any request -> SS_n low 520 clk per frame; SS_n high exactly 2 clk between frames; SCLK period 32 clk with 16 rising edges per frame; SCLK high whenever SS_n is high.
- Issue requests on channels 1,0,4,2,3,7 with the model returning 12'h001, 12'h800, 12'hFFF, ... -> frame 1 carries the matching channel in bits [13:11]; `res` matches each value exactly.
- Second `strt_cnv` at clk 300 of a conversion -> it is ignored; one completion only; `res` belongs to the first channel.
- Assert `rst_n` low at clk 700 of a conversion -> SS_n=1 and SCLK=1 immediately; `cnv_cmplt`=0; `res`=0; a new request afterwards completes normally.
- After completion, hold `strt_cnv` low for 5000 clk -> `cnv_cmplt` stays 1 and `res` is stable. The next `strt_cnv` drops `cnv_cmplt` on its accepting edge.

Source files
------------

// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and constants for the A2D conversion interface.
// Build option: define A2D_INV_RES_EN to present the inverted ADC code on res.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    XFER1,
    GAP,
    XFER2,
    DONE
  } a2d_state_t;

  localparam logic [1:0] A2D_FRAME_PAD = 2'b00;
  localparam logic [4:0] SCLK_LOAD     = 5'b10111;
  localparam int         FRAME_BITS    = 16;

  // Channel-select frame sent to the ADC: pad, channel, then zero fill.
  function automatic logic [15:0] a2d_cmd_frame(input logic [2:0] ch);
    return {A2D_FRAME_PAD, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_intf_spi_mstr16.sv
// spi_mstr16: 16-bit SPI master. SCLK idles high, the ADC samples MOSI on
// SCLK rise, MISO is captured on SCLK rise and shifted in on SCLK fall.
// The first fall (end of the front porch) is not a shift, and the 16th
// half-period ends the frame without a 17th fall. SCLK_DIV_W must be >= 4.
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [SCLK_DIV_W-1:0] DIV_ONE  = SCLK_DIV_W'(1);
  localparam logic [SCLK_DIV_W-1:0] DIV_MAX  = '1;
  localparam logic [SCLK_DIV_W-1:0] DIV_LAST = DIV_MAX - DIV_ONE;
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = DIV_MAX >> 1;
  localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = DIV_MAX - SCLK_DIV_W'(5'd31 - SCLK_LOAD);
  localparam logic [4:0]            LAST_RISE = 5'(FRAME_BITS);

  logic [SCLK_DIV_W-1:0] div;
  logic [15:0]           shreg;
  logic [4:0]            rise_cnt;
  logic                  miso_hold;
  logic                  first_fall;
  logic                  ss_n_r;
  logic                  done_r;

  // Frame sequencing: divider, MISO capture on rise, shift on fall, frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_r     <= 1'b1;
      div        <= '0;
      shreg      <= '0;
      rise_cnt   <= '0;
      miso_hold  <= 1'b0;
      first_fall <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (ss_n_r) begin
        if (wrt) begin
          ss_n_r     <= 1'b0;
          div        <= DIV_LOAD;
          shreg      <= cmd;
          rise_cnt   <= '0;
          first_fall <= 1'b1;
        end
      end else begin
        div <= div + DIV_ONE;
        if (div == DIV_RISE) begin
          miso_hold <= MISO;
          rise_cnt  <= rise_cnt + 5'd1;
        end
        if ((rise_cnt == LAST_RISE) && (div == DIV_LAST)) begin
          shreg  <= {shreg[14:0], miso_hold};
          ss_n_r <= 1'b1;
          done_r <= 1'b1;
        end else if (div == DIV_MAX) begin
          if (first_fall) begin
            first_fall <= 1'b0;
          end else begin
            shreg <= {shreg[14:0], miso_hold};
          end
        end
      end
    end
  end

  assign SS_n    = ss_n_r;
  assign SCLK    = ss_n_r | div[SCLK_DIV_W-1];
  assign MOSI    = shreg[15];
  assign rd_data = shreg;
  assign done    = done_r;

endmodule

// File: rtl/a2d_intf.sv
// a2d_intf: conversion handshake responder. One strt_cnv runs two SPI frames
// (channel select, then sample read) and presents the 12-bit result on res
// with cnv_cmplt as a level until the next accepted request.
// Build option: A2D_INV_RES_EN inverts the presented code for the IR front end.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5,
  parameter int GAP_CLKS   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  // The gap counter starts at 2 because SS_n has already been high for one
  // clk when the done pulse is seen, and wrt lands one clk later still.
  localparam logic [7:0] GAP_LIMIT = 8'(GAP_CLKS);
  localparam logic [7:0] GAP_ENTRY = 8'd2;

  a2d_state_t  state;
  a2d_state_t  nxt_state;
  logic [2:0]  chnl_lat;
  logic [7:0]  gap_cnt;
  logic        gap_go;
  logic        wrt;
  logic [15:0] cmd;
  logic        spi_done;
  logic [15:0] rx_data;
  logic [11:0] res_next;
  logic        unused_rx_hi;

  assign gap_go       = (gap_cnt >= GAP_LIMIT);
  assign unused_rx_hi = ^rx_data[15:12];

`ifdef A2D_INV_RES_EN
  assign res_next = ~rx_data[11:0];
`else
  assign res_next = rx_data[11:0];
`endif

  spi_mstr16 #(
    .SCLK_DIV_W(SCLK_DIV_W)
  ) u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrt    (wrt),
    .cmd    (cmd),
    .done   (spi_done),
    .rd_data(rx_data),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  // Next-state: two frames separated by the gap, then one clk in DONE.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (strt_cnv) nxt_state = XFER1;
      XFER1:   if (spi_done) nxt_state = GAP;
      GAP:     if (gap_go)   nxt_state = XFER2;
      XFER2:   if (spi_done) nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Frame launch: first frame starts on the accepting edge, second after the gap.
  always_comb begin
    wrt = 1'b0;
    cmd = a2d_cmd_frame(chnl_lat);
    case (state)
      IDLE: begin
        wrt = strt_cnv;
        cmd = a2d_cmd_frame(chnnl);
      end
      GAP:     wrt = gap_go;
      default: wrt = 1'b0;
    endcase
  end

  // Channel latch and inter-frame gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chnl_lat <= '0;
      gap_cnt  <= '0;
    end else begin
      if ((state == IDLE) && strt_cnv) begin
        chnl_lat <= chnnl;
      end
      if ((state == XFER1) && spi_done) begin
        gap_cnt <= GAP_ENTRY;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

  // Result and completion flag update together as the second frame finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnv_cmplt <= 1'b0;
      res       <= '0;
    end else begin
      if ((state == IDLE) && strt_cnv) begin
        cnv_cmplt <= 1'b0;
      end else if ((state == XFER2) && spi_done) begin
        cnv_cmplt <= 1'b1;
        res       <= res_next;
      end
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// tb_a2d_intf: self-checking bench for a2d_intf with a behavioural ADC model.
// Honours A2D_INV_RES_EN when computing expected results.
module tb_a2d_intf;

  logic        clk;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int passed = 0;
  int total  = 0;

  localparam int LAT = 1043;

  a2d_intf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: per-channel sample memory; the frame read back returns the
  // sample of the channel named by the previous frame, 4 junk bits on top.
  logic [11:0] adc_mem [8];
  logic [15:0] adc_frame = '0;
  logic [15:0] mosi_sr   = '0;
  logic [2:0]  sel_ch    = '0;
  int          nrises    = 0;
  logic        ss_q      = 1'b1;
  logic        sclk_q    = 1'b1;
  logic [15:0] mosi_q [$];

  always @(SS_n or SCLK) begin
    if (SS_n === 1'b0 && ss_q !== 1'b0) begin
      adc_frame = {4'($urandom), adc_mem[sel_ch]};
      nrises    = 0;
      mosi_sr   = '0;
    end else if (SS_n === 1'b1 && ss_q === 1'b0) begin
      mosi_q.push_back(mosi_sr);
      sel_ch = mosi_sr[13:11];
    end else if (SS_n === 1'b0 && SCLK === 1'b1 && sclk_q === 1'b0) begin
      mosi_sr = {mosi_sr[14:0], MOSI};
      nrises  = nrises + 1;
    end
    ss_q   = SS_n;
    sclk_q = SCLK;
  end

  assign MISO = (SS_n === 1'b0 && nrises < 16) ? adc_frame[4'(15 - nrises)] : 1'b0;

  // Timing monitor sampled on the falling clk edge.
  int low_q [$];
  int gap_q [$];
  int rise_q [$];
  int period_q [$];
  int sclk_bad = 0;
  int low_run = 0, high_run = 0, rise_f = 0, last_rise = 0, cyc_n = 0;
  logic prev_ss = 1'b1, prev_sclk = 1'b1;

  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (rst_n !== 1'b1) begin
      low_run = 0; high_run = 0; rise_f = 0;
      prev_ss = 1'b1; prev_sclk = 1'b1;
    end else begin
      if (SS_n === 1'b1 && SCLK !== 1'b1) sclk_bad = sclk_bad + 1;
      if (SS_n === 1'b0) begin
        if (prev_ss) begin
          gap_q.push_back(high_run);
          high_run = 0; low_run = 0; rise_f = 0;
        end
        low_run = low_run + 1;
        if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
          if (rise_f > 0) period_q.push_back(cyc_n - last_rise);
          last_rise = cyc_n;
          rise_f = rise_f + 1;
        end
      end else begin
        if (!prev_ss) begin
          low_q.push_back(low_run);
          rise_q.push_back(rise_f);
        end
        high_run = high_run + 1;
      end
      prev_ss   = SS_n;
      prev_sclk = SCLK;
    end
  end

  // Reference: the presented code is the selected channel's sample.
  function automatic logic [11:0] exp_res(input logic [11:0] s);
`ifdef A2D_INV_RES_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  task automatic run_conv(input logic [2:0] ch, output int lat);
    repeat (2) @(negedge clk);
    chnnl = ch;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    chnnl = 3'($urandom);
    lat = 0;
    while (cnv_cmplt !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; strt_cnv = 1'b0; chnnl = 3'd0;
    for (int k = 0; k < 8; k++) adc_mem[k] = 12'(k * 16'h111);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (SS_n !== 1'b1) $display("[TB] FAIL reset_ss_n: got %b expected 1", SS_n); else passed++;
    total++; if (SCLK !== 1'b1) $display("[TB] FAIL reset_sclk: got %b expected 1", SCLK); else passed++;
    total++; if (MOSI !== 1'b0) $display("[TB] FAIL reset_mosi: got %b expected 0", MOSI); else passed++;
    total++; if (cnv_cmplt !== 1'b0) $display("[TB] FAIL reset_cmplt: got %b expected 0", cnv_cmplt); else passed++;
    total++; if (res !== 12'h000) $display("[TB] FAIL reset_res: got %h expected 000", res); else passed++;
  endtask

  task automatic test_basic();
    int lat, mb, lb, gb, pb, bad0, pbad;
    logic [15:0] f;
    mb = mosi_q.size(); lb = low_q.size(); gb = gap_q.size();
    pb = period_q.size(); bad0 = sclk_bad; pbad = 0;
    adc_mem[4] = 12'hA5C;
    run_conv(3'd4, lat);
    total++; if (lat !== LAT) $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, LAT); else passed++;
    f = (mosi_q.size() > mb) ? mosi_q[mb] : 16'hxxxx;
    total++; if (f !== 16'h2000) $display("[TB] FAIL basic_frame1: got %h expected 2000", f); else passed++;
    total++; if (res !== exp_res(12'hA5C)) $display("[TB] FAIL basic_res: got %h expected %h", res, exp_res(12'hA5C)); else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (low_q.size() < lb + 2 || low_q[lb+i] !== 520 || rise_q[lb+i] !== 16)
        $display("[TB] FAIL frame%0d_timing: low/rises got %0d/%0d expected 520/16", i + 1,
                 (low_q.size() > lb + i) ? low_q[lb+i] : -1, (rise_q.size() > lb + i) ? rise_q[lb+i] : -1);
      else passed++;
    end
    total++;
    if (gap_q.size() < gb + 2 || gap_q[gb+1] !== 2)
      $display("[TB] FAIL gap_len: got %0d expected 2", (gap_q.size() > gb + 1) ? gap_q[gb+1] : -1);
    else passed++;
    for (int i = pb; i < period_q.size(); i++) if (period_q[i] !== 32) pbad++;
    total++;
    if (pbad != 0 || period_q.size() != pb + 30)
      $display("[TB] FAIL sclk_period: bad %0d of %0d periods, expected 0 of 30", pbad, period_q.size() - pb);
    else passed++;
    total++; if (sclk_bad !== bad0) $display("[TB] FAIL sclk_idle_high: got %0d violations expected 0", sclk_bad - bad0); else passed++;
  endtask

  task automatic test_channels();
    logic [2:0]  chs  [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    logic [11:0] vals [6] = '{12'h001, 12'h800, 12'hFFF, 12'h3C5, 12'h7FE, 12'h124};
    int lat, mb;
    logic [15:0] f, fexp;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) adc_mem[k] = vals[i] ^ 12'(k + 1);
      adc_mem[chs[i]] = vals[i];
      mb = mosi_q.size();
      run_conv(chs[i], lat);
      fexp = {2'b00, chs[i], 11'h000};
      f = (mosi_q.size() > mb) ? mosi_q[mb] : 16'hxxxx;
      total++; if (f !== fexp) $display("[TB] FAIL chan%0d_frame1: got %h expected %h", chs[i], f, fexp); else passed++;
      total++; if (res !== exp_res(vals[i])) $display("[TB] FAIL chan%0d_res: got %h expected %h", chs[i], res, exp_res(vals[i])); else passed++;
    end
  endtask

  task automatic test_random();
    int lat;
    logic [2:0] ch;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) adc_mem[k] = 12'($urandom);
      ch = 3'($urandom_range(0, 7));
      run_conv(ch, lat);
      total++;
      if (lat !== LAT || res !== exp_res(adc_mem[ch]))
        $display("[TB] FAIL rand%0d_ch%0d: got lat %0d res %h expected lat %0d res %h", i, ch, lat, res, LAT, exp_res(adc_mem[ch]));
      else passed++;
    end
  endtask

  task automatic test_busy_ignore();
    int lat, lb;
    for (int k = 0; k < 8; k++) adc_mem[k] = 12'h100 + 12'(k * 7);
    lb = low_q.size();
    repeat (2) @(negedge clk);
    chnnl = 3'd5; strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    lat = 0;
    while (cnv_cmplt !== 1'b1 && lat < 2000) begin
      if (lat == 300) begin chnnl = 3'd2; strt_cnv = 1'b1; end
      else strt_cnv = 1'b0;
      @(negedge clk);
      lat++;
    end
    strt_cnv = 1'b0;
    total++; if (lat !== LAT) $display("[TB] FAIL busy_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (res !== exp_res(adc_mem[5])) $display("[TB] FAIL busy_res: got %h expected %h", res, exp_res(adc_mem[5])); else passed++;
    repeat (1200) @(negedge clk);
    total++;
    if (low_q.size() !== lb + 2 || cnv_cmplt !== 1'b1)
      $display("[TB] FAIL busy_single: got %0d frames cmplt %b expected 2 frames cmplt 1", low_q.size() - lb, cnv_cmplt);
    else passed++;
  endtask

  task automatic test_done_window();
    int lat, bad;
    adc_mem[2] = 12'($urandom) | 12'h010;
    run_conv(3'd2, lat);
    chnnl = 3'd6; strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (SS_n !== 1'b1 || cnv_cmplt !== 1'b1) bad++;
    end
    total++; if (bad != 0 || lat !== LAT) $display("[TB] FAIL done_window: got %0d busy samples lat %0d expected 0 lat %0d", bad, lat, LAT); else passed++;
    total++; if (res !== exp_res(adc_mem[2])) $display("[TB] FAIL done_window_res: got %h expected %h", res, exp_res(adc_mem[2])); else passed++;
  endtask

  task automatic test_hold();
    int bad, lat;
    logic [11:0] r0;
    r0 = res;
    bad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (cnv_cmplt !== 1'b1 || res !== r0) bad++;
    end
    total++; if (bad != 0) $display("[TB] FAIL hold_stable: got %0d unstable samples expected 0", bad); else passed++;
    adc_mem[1] = 12'h6D2;
    chnnl = 3'd1; strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    total++; if (cnv_cmplt !== 1'b0) $display("[TB] FAIL hold_drop: got %b expected 0", cnv_cmplt); else passed++;
    lat = 0;
    while (cnv_cmplt !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== LAT || res !== exp_res(12'h6D2)) $display("[TB] FAIL hold_next: got lat %0d res %h expected lat %0d res %h", lat, res, LAT, exp_res(12'h6D2)); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    repeat (2) @(negedge clk);
    chnnl = 3'd6; strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    repeat (700) @(negedge clk);
    total++; if (SS_n !== 1'b0) $display("[TB] FAIL midrst_busy: got SS_n %b expected 0", SS_n); else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (SS_n !== 1'b1 || SCLK !== 1'b1 || cnv_cmplt !== 1'b0 || res !== 12'h000)
      $display("[TB] FAIL midrst_values: got ss %b sclk %b cmplt %b res %h expected 1 1 0 000", SS_n, SCLK, cnv_cmplt, res);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    adc_mem[3] = 12'h9B1;
    run_conv(3'd3, lat);
    total++; if (lat !== LAT || res !== exp_res(12'h9B1)) $display("[TB] FAIL midrst_recover: got lat %0d res %h expected lat %0d res %h", lat, res, LAT, exp_res(12'h9B1)); else passed++;
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_channels();
    test_random();
    test_busy_ignore();
    test_done_window();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
